rx_substate_checker: RTL and testbench
======================================

RX_SUBSTATE_CHECKER -- requirements
Module: rx_substate_checker

Interface
REQ-001 SHALL have parameter MAXLANES, default 16: number of lanes checked.
REQ-002 SHALL have parameter DEVICETYPE, default 0: 0 = downstream, 1 = upstream.
REQ-003 SHALL have parameter CNT_W, default 5: per-lane ordered-set counter width.
REQ-004 SHALL have parameter TICKS_PER_MS, default 1000: clk cycles per millisecond.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port substate, input, 5 bits: LTSSM substate code to check.
REQ-008 SHALL have port substateValid, input, 1 bit: request strobe.
REQ-009 SHALL have port activeLanes, input, MAXLANES bits: lane mask.
REQ-010 SHALL have port osMatch, input, MAXLANES bits: per lane, qualifying ordered set received this cycle.
REQ-011 SHALL have port osMismatch, input, MAXLANES bits: per lane, non-qualifying ordered set received this cycle.
REQ-012 SHALL have port rxElectricalIdle, input, MAXLANES bits: per-lane electrical idle.
REQ-013 SHALL have port padTs, input, 1 bit: received TS carries PAD link/lane number.
REQ-014 SHALL have port busy, output, 1 bit: a request is in progress.
REQ-015 SHALL have port finish, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port failed, output, 1 bit: outcome qualifier, valid with finish.
REQ-017 SHALL have port exitTo, output, 5 bits: next substate, valid with finish.
REQ-018 SHALL have port laneDone, output, MAXLANES bits: lanes whose count has reached target.

Function
REQ-019 SHALL implement FSM states IDLE, ARM, COUNT, DONE: IDLE->ARM on substateValid; ARM->COUNT after 1 cycle; COUNT->DONE on success or fail; DONE->IDLE after 1 cycle.
REQ-020 SHALL latch substate in IDLE on substateValid; substate changes after that point are ignored until IDLE is re-entered.
REQ-021 SHALL ignore substateValid outside IDLE; busy is high in ARM, COUNT and DONE.
REQ-022 SHALL, in ARM, clear all lane counters, load target count and timeout from the package table, and start the timer.
REQ-023 SHALL use this table (target count / timeout):
- pollingActive: 8 / 24 ms
- pollingConfiguration: 8 / 48 ms
- recoveryRcvrCfg: 8 / 48 ms
- cfgLinkWidthStart: 1 / 24 ms
- cfgLinkWidthAccept: 1 / 2 ms
- cfgLanenumWait and cfgLanenumAccept: 2 / 2 ms
- cfgComplete: 8 / 2 ms
- cfgIdle and recoveryIdle: 8 / 2 ms
- recoveryRcvrLock: 8 / 24 ms
- recoverySpeed: 1 / 48 ms
- phase0 and phase1: 2 / 12 ms; phase1 target is 0 when DEVICETYPE=0
- detectQuiet: 0 / 12 ms
- detectActive: 0 / 0 ms
- all other codes: 0 / 0 ms
REQ-024 SHALL update each lane counter in COUNT as follows:
- osMatch increments the counter, saturating at target.
- osMismatch alone clears the counter to 0.
- osMatch and osMismatch together set the counter to 1.
REQ-025 SHALL declare success when activeLanes is nonzero and every active lane has count >= target; inactive lanes are ignored.
REQ-026 SHALL make detectQuiet succeed on timeout, or when any active lane has rxElectricalIdle deasserted.
REQ-027 SHALL make detectActive succeed in the first COUNT cycle.
REQ-028 SHALL declare fail on timer expiry without success; success and expiry in the same cycle gives success.
REQ-029 SHALL turn success into fail for cfgLanenumWait and cfgLanenumAccept when padTs=1 in the deciding cycle.
REQ-030 SHALL, in DONE, assert finish=1 and drive failed and exitTo:
- Success exitTo: recoveryIdle->L0; recoverySpeed->recoveryRcvrLock; otherwise substate+1.
- Fail exitTo: phase0/phase1->recoverySpeed; otherwise detectQuiet.
REQ-031 SHALL hold exitTo and failed stable until the next DONE.
REQ-032 SHALL give a latency from substateValid to finish of at least 3 cycles; an immediate decision gives exactly 3.

Reset
REQ-033 SHALL, while reset=0, force state IDLE, busy=0, finish=0, failed=0, exitTo=0, laneDone=0, counters 0 and timer stopped.
REQ-034 SHALL, on reset mid-operation, abort with no finish pulse; on release, operation resumes from IDLE.

Configuration
REQ-035 SHALL, with macro RXSM_ABORT_EN defined, add input abortReq, 1 bit: when high in ARM/COUNT, return to IDLE next cycle with no finish and counters cleared.
REQ-036 SHALL, without RXSM_ABORT_EN, have no abortReq port and no abort logic.

Structure
REQ-037 SHALL take substate codes, the timeout enumeration, and the target/timeout table function from shared package ltssm_pkg.
REQ-038 SHALL instantiate sub-module ltssm_timeout_timer (ms-scaled down-counter with start, load value and expired outputs).

Verification
REQ-039 SHALL cover: MAXLANES=4, activeLanes=4'b1111, pollingActive, 8 osMatch on all lanes -> finish=1, failed=0, exitTo=pollingConfiguration.
REQ-040 SHALL cover: lane 2 osMismatch after 7 matches, then 8 more matches -> success only after the 15th lane-2 match.
REQ-041 SHALL cover: cfgLinkWidthAccept with no OS for 2*TICKS_PER_MS cycles -> finish with failed=1, exitTo=detectQuiet.
REQ-042 SHALL cover: cfgLanenumWait, 2 matches with padTs=1 -> failed=1, exitTo=detectQuiet.
REQ-043 SHALL cover: phase0 timeout -> exitTo=recoverySpeed.
REQ-044 SHALL cover: final match in the same cycle as expiry -> success.
REQ-045 SHALL cover: reset asserted in COUNT -> no finish, busy=0.

Source files
------------

// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: substate codes, timeout enumeration and the
// per-substate ordered-set target / timeout table.
package ltssm_pkg;

  typedef enum logic [4:0] {
    detectQuiet          = 5'd0,
    detectActive         = 5'd1,
    pollingActive        = 5'd2,
    pollingConfiguration = 5'd3,
    cfgLinkWidthStart    = 5'd4,
    cfgLinkWidthAccept   = 5'd5,
    cfgLanenumWait       = 5'd6,
    cfgLanenumAccept     = 5'd7,
    cfgComplete          = 5'd8,
    cfgIdle              = 5'd9,
    L0                   = 5'd10,
    recoveryRcvrLock     = 5'd11,
    recoveryRcvrCfg      = 5'd12,
    recoverySpeed        = 5'd13,
    recoveryIdle         = 5'd14,
    phase0               = 5'd15,
    phase1               = 5'd16
  } substate_e;

  typedef enum logic [2:0] {TO_0MS, TO_2MS, TO_12MS, TO_24MS, TO_48MS} timeout_e;

  typedef struct packed {
    logic [3:0] target;
    timeout_e   timeout;
  } os_req_t;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} chk_state_e;

  function automatic logic [5:0] timeout_ms(input timeout_e t);
    case (t)
      TO_2MS:  return 6'd2;
      TO_12MS: return 6'd12;
      TO_24MS: return 6'd24;
      TO_48MS: return 6'd48;
      default: return 6'd0;
    endcase
  endfunction

  function automatic os_req_t substate_req(input logic [4:0] s, input logic upstream);
    os_req_t r;
    r.target  = 4'd0;
    r.timeout = TO_0MS;
    case (s)
      pollingActive:                    begin r.target = 4'd8; r.timeout = TO_24MS; end
      pollingConfiguration:             begin r.target = 4'd8; r.timeout = TO_48MS; end
      recoveryRcvrCfg:                  begin r.target = 4'd8; r.timeout = TO_48MS; end
      cfgLinkWidthStart:                begin r.target = 4'd1; r.timeout = TO_24MS; end
      cfgLinkWidthAccept:               begin r.target = 4'd1; r.timeout = TO_2MS;  end
      cfgLanenumWait, cfgLanenumAccept: begin r.target = 4'd2; r.timeout = TO_2MS;  end
      cfgComplete:                      begin r.target = 4'd8; r.timeout = TO_2MS;  end
      cfgIdle, recoveryIdle:            begin r.target = 4'd8; r.timeout = TO_2MS;  end
      recoveryRcvrLock:                 begin r.target = 4'd8; r.timeout = TO_24MS; end
      recoverySpeed:                    begin r.target = 4'd1; r.timeout = TO_48MS; end
      phase0:                           begin r.target = 4'd2; r.timeout = TO_12MS; end
      // Downstream ports do not wait for TS1s in phase1.
      phase1:                           begin r.target = upstream ? 4'd2 : 4'd0; r.timeout = TO_12MS; end
      detectQuiet:                      begin r.target = 4'd0; r.timeout = TO_12MS; end
      default:                          begin r.target = 4'd0; r.timeout = TO_0MS;  end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ltssm_timeout_timer.sv
// Millisecond down-counter: start loads load_ms, expired is high once the
// loaded number of milliseconds has elapsed, until stop.
module ltssm_timeout_timer #(
  parameter int TICKS_PER_MS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [5:0] load_ms,
  output logic       expired
);
  localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_MS - 1);

  logic          running;
  logic [5:0]    ms_left;
  logic [TW-1:0] tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running <= 1'b0;
      ms_left <= '0;
      tick    <= '0;
    end else if (start) begin
      running <= 1'b1;
      ms_left <= load_ms;
      tick    <= '0;
    end else if (stop) begin
      running <= 1'b0;
      ms_left <= '0;
      tick    <= '0;
    end else if (running && ms_left != 6'd0) begin
      if (tick == TICK_LAST) begin
        tick    <= '0;
        ms_left <= ms_left - 6'd1;
      end else begin
        tick <= tick + TW'(1);
      end
    end
  end

  assign expired = running && (ms_left == 6'd0);

endmodule

// File: rtl/rx_substate_checker.sv
// Per-lane ordered-set counting checker for one LTSSM substate request.
// Optional RXSM_ABORT_EN adds abortReq to cancel a request in ARM/COUNT.
module rx_substate_checker
  import ltssm_pkg::*;
#(
  parameter int MAXLANES     = 16,
  parameter int DEVICETYPE   = 0,
  parameter int CNT_W        = 5,
  parameter int TICKS_PER_MS = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          substate,
  input  logic                substateValid,
  input  logic [MAXLANES-1:0] activeLanes,
  input  logic [MAXLANES-1:0] osMatch,
  input  logic [MAXLANES-1:0] osMismatch,
  input  logic [MAXLANES-1:0] rxElectricalIdle,
  input  logic                padTs,
`ifdef RXSM_ABORT_EN
  input  logic                abortReq,
`endif
  output logic                busy,
  output logic                finish,
  output logic                failed,
  output logic [4:0]          exitTo,
  output logic [MAXLANES-1:0] laneDone
);

  chk_state_e          state, state_nxt;
  logic [4:0]          sub_q;
  logic [3:0]          target_q;
  logic [CNT_W-1:0]    tgt;
  os_req_t             req;
  logic                expired, abort, succ, pad_fail, decide, fail_d;
  logic [4:0]          exit_d;
  logic [MAXLANES-1:0] lane_ok, lane_hit;

  assign req = substate_req(sub_q, DEVICETYPE != 0);
  assign tgt = CNT_W'(target_q);

`ifdef RXSM_ABORT_EN
  assign abort = abortReq && (state == S_ARM || state == S_COUNT);
`else
  assign abort = 1'b0;
`endif

  ltssm_timeout_timer #(.TICKS_PER_MS(TICKS_PER_MS)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (state == S_ARM && !abort),
    .stop    (state != S_COUNT || abort),
    .load_ms (timeout_ms(req.timeout)),
    .expired (expired)
  );

  for (genvar i = 0; i < MAXLANES; i++) begin : g_lane
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    always_comb begin
      cnt_nxt = cnt_q;
      if (osMatch[i] && osMismatch[i])   cnt_nxt = CNT_W'(1);
      else if (osMismatch[i])            cnt_nxt = '0;
      else if (osMatch[i] && cnt_q < tgt) cnt_nxt = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          cnt_q <= '0;
      else if (state == S_ARM || abort)    cnt_q <= '0;
      else if (state == S_COUNT)           cnt_q <= cnt_nxt;
    end

    // Decisions look at the post-update count so a match in the expiry cycle still counts.
    assign lane_hit[i] = (cnt_nxt >= tgt);
    assign lane_ok[i]  = !activeLanes[i] || lane_hit[i];
  end

  always_comb begin
    succ = (|activeLanes) && (&lane_ok);
    if (sub_q == detectActive)     succ = 1'b1;
    else if (sub_q == detectQuiet) succ = expired || (|(activeLanes & ~rxElectricalIdle));
  end

  assign pad_fail = padTs && (sub_q == cfgLanenumWait || sub_q == cfgLanenumAccept);
  assign decide   = (state == S_COUNT) && (succ || expired);
  assign fail_d   = !succ || pad_fail;

  always_comb begin
    exit_d = sub_q + 5'd1;
    if (fail_d) begin
      exit_d = (sub_q == phase0 || sub_q == phase1) ? 5'(recoverySpeed) : 5'(detectQuiet);
    end else if (sub_q == recoveryIdle) begin
      exit_d = 5'(L0);
    end else if (sub_q == recoverySpeed) begin
      exit_d = 5'(recoveryRcvrLock);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (substateValid) state_nxt = S_ARM;
      S_ARM:   state_nxt = abort ? S_IDLE : S_COUNT;
      S_COUNT: begin
        if (abort)       state_nxt = S_IDLE;
        else if (decide) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_q    <= '0;
      target_q <= '0;
      failed   <= 1'b0;
      exitTo   <= '0;
      laneDone <= '0;
    end else begin
      if (state == S_IDLE && substateValid) sub_q <= substate;
      if (state == S_ARM) begin
        target_q <= req.target;
        laneDone <= '0;
      end
      if (abort) begin
        laneDone <= '0;
      end else if (state == S_COUNT) begin
        laneDone <= lane_hit;
        if (decide) begin
          failed <= fail_d;
          exitTo <= exit_d;
        end
      end
    end
  end

  assign busy   = (state != S_IDLE);
  assign finish = (state == S_DONE);

endmodule

// File: tb/tb_rx_substate_checker.sv
// Bench for rx_substate_checker: vector table plus hand-written corner sequences,
// expected outcomes queued at request time and checked when finish pulses.
module tb_rx_substate_checker;
  import ltssm_pkg::*;

  localparam int NL  = 4;
  localparam int TPM = 10;

  logic          clk, reset;
  logic [4:0]    substate;
  logic          substateValid;
  logic [NL-1:0] activeLanes, osMatch, osMismatch, rxElectricalIdle;
  logic          padTs;
  logic          busy, finish, failed;
  logic [4:0]    exitTo;
  logic [NL-1:0] laneDone;

  rx_substate_checker #(.MAXLANES(NL), .DEVICETYPE(0), .CNT_W(5), .TICKS_PER_MS(TPM)) dut (
    .clk(clk), .reset(reset), .substate(substate), .substateValid(substateValid),
    .activeLanes(activeLanes), .osMatch(osMatch), .osMismatch(osMismatch),
    .rxElectricalIdle(rxElectricalIdle), .padTs(padTs),
    .busy(busy), .finish(finish), .failed(failed), .exitTo(exitTo), .laneDone(laneDone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ncmp = 0;
  int nfail = 0;

  typedef struct {
    int         id;
    logic       f;
    logic [4:0] e;
    int         c;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [4:0]    sub;
    logic [NL-1:0] act;
    logic [NL-1:0] eidle;
    int            n;
    logic          pad;
    logic          f;
    logic [4:0]    e;
    int            lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (reset && finish) begin
      if (sb.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_finish: finish=1 at cycle %0d, required 0", cyc);
      end else begin : pop
        exp_t x;
        x = sb.pop_front();
        chk($sformatf("t%0d_failed", x.id), 32'(failed), 32'(x.f));
        chk($sformatf("t%0d_exitTo", x.id), 32'(exitTo), 32'(x.e));
        chk($sformatf("t%0d_finish_cycle", x.id), cyc, x.c);
      end
    end
  end

  // Pulses substateValid in IDLE and returns #1 into the first COUNT cycle.
  task automatic start_req(input int id, input logic [4:0] s, input logic f,
                           input logic [4:0] e, input int lat);
    exp_t x;
    @(posedge clk); #1;
    substate = s;
    substateValid = 1'b1;
    x.id = id; x.f = f; x.e = e; x.c = cyc + lat;
    sb.push_back(x);
    @(posedge clk); #1;
    substateValid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int id, input int bound);
    int k = 0;
    osMatch = '0;
    osMismatch = '0;
    while (sb.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      ncmp++;
      nfail++;
      $display("FAIL t%0d_timeout: no finish within %0d cycles, required one", id, bound);
      sb.delete();
    end
    padTs = 1'b0;
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{5'(pollingActive),      4'hF, 4'hF, 8, 1'b0, 1'b0, 5'(pollingConfiguration), 10};
    tbl[1]  = '{5'(cfgLinkWidthStart),  4'h3, 4'hF, 1, 1'b0, 1'b0, 5'(cfgLinkWidthAccept),   3};
    tbl[2]  = '{5'(cfgLinkWidthAccept), 4'hF, 4'hF, 0, 1'b0, 1'b1, 5'(detectQuiet),          3 + 2*TPM};
    tbl[3]  = '{5'(cfgLanenumWait),     4'hF, 4'hF, 2, 1'b1, 1'b1, 5'(detectQuiet),          4};
    tbl[4]  = '{5'(cfgLanenumAccept),   4'hF, 4'hF, 2, 1'b0, 1'b0, 5'(cfgComplete),          4};
    tbl[5]  = '{5'(phase0),             4'hF, 4'hF, 0, 1'b0, 1'b1, 5'(recoverySpeed),        3 + 12*TPM};
    tbl[6]  = '{5'(phase1),             4'hF, 4'hF, 0, 1'b0, 1'b0, 5'd17,                    3};
    tbl[7]  = '{5'(recoveryIdle),       4'hF, 4'hF, 8, 1'b0, 1'b0, 5'(L0),                   10};
    tbl[8]  = '{5'(recoverySpeed),      4'hF, 4'hF, 1, 1'b0, 1'b0, 5'(recoveryRcvrLock),     3};
    tbl[9]  = '{5'(detectActive),       4'h0, 4'hF, 0, 1'b0, 1'b0, 5'(pollingActive),        3};
    tbl[10] = '{5'(detectQuiet),        4'hF, 4'hF, 0, 1'b0, 1'b0, 5'(detectActive),         3 + 12*TPM};
    tbl[11] = '{5'(detectQuiet),        4'hF, 4'hB, 0, 1'b0, 1'b0, 5'(detectActive),         3};
    tbl[12] = '{5'd20,                  4'h0, 4'hF, 0, 1'b0, 1'b1, 5'(detectQuiet),          3};
    tbl[13] = '{5'(pollingActive),      4'h5, 4'hF, 8, 1'b0, 1'b0, 5'(pollingConfiguration), 10};
    tbl[14] = '{5'(cfgLinkWidthAccept), 4'h0, 4'hF, 3, 1'b0, 1'b1, 5'(detectQuiet),          3 + 2*TPM};
    tbl[15] = '{5'(recoveryRcvrCfg),    4'hF, 4'hF, 8, 1'b0, 1'b0, 5'(recoverySpeed),        10};

    reset = 1'b0;
    substate = '0; substateValid = 1'b0; activeLanes = '0; osMatch = '0;
    osMismatch = '0; rxElectricalIdle = '1; padTs = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_finish", 32'(finish), 0);
    chk("rst_failed", 32'(failed), 0);
    chk("rst_exitTo", 32'(exitTo), 0);
    chk("rst_laneDone", 32'(laneDone), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      activeLanes = tbl[i].act;
      rxElectricalIdle = tbl[i].eidle;
      padTs = tbl[i].pad;
      start_req(i, tbl[i].sub, tbl[i].f, tbl[i].e, tbl[i].lat);
      for (int k = 0; k < tbl[i].n; k++) begin
        osMatch = tbl[i].act;
        @(posedge clk); #1;
      end
      wait_done(i, 300);
    end
    repeat (3) @(negedge clk);
    chk("exit_hold", 32'(exitTo), 32'(tbl[15].e));
    chk("failed_hold", 32'(failed), 32'(tbl[15].f));

    // Lane 2 mismatch after 7 matches; substate input change is ignored.
    activeLanes = 4'hF; rxElectricalIdle = 4'hF;
    start_req(100, 5'(pollingActive), 1'b0, 5'(pollingConfiguration), 18);
    for (int k = 0; k < 16; k++) begin
      osMatch    = (k == 7) ? 4'b1011 : 4'b1111;
      osMismatch = (k == 7) ? 4'b0100 : 4'b0000;
      if (k == 1) substate = 5'(detectActive);
      if (k == 8) chk("t100_laneDone", 32'(laneDone), 32'b1011);
      @(posedge clk); #1;
    end
    wait_done(100, 100);

    // Match together with mismatch restarts the lane at 1.
    start_req(101, 5'(cfgLanenumWait), 1'b0, 5'(cfgLanenumAccept), 5);
    for (int k = 0; k < 3; k++) begin
      osMatch    = 4'hF;
      osMismatch = (k == 1) ? 4'b0001 : 4'b0000;
      @(posedge clk); #1;
    end
    wait_done(101, 100);

    // Last needed match lands in the expiry cycle.
    start_req(102, 5'(cfgLinkWidthAccept), 1'b0, 5'(cfgLanenumWait), 3 + 2*TPM);
    for (int k = 0; k <= 2*TPM; k++) begin
      osMatch = (k == 2*TPM) ? 4'hF : 4'h0;
      @(posedge clk); #1;
    end
    wait_done(102, 100);

    // Reset while counting: no finish, everything cleared, then normal service.
    @(posedge clk); #1;
    substate = 5'(pollingActive);
    substateValid = 1'b1;
    @(posedge clk); #1;
    substateValid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      osMatch = 4'hF;
    end
    chk("t103_busy_count", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("t103_rst_busy", 32'(busy), 0);
    chk("t103_rst_finish", 32'(finish), 0);
    chk("t103_rst_exitTo", 32'(exitTo), 0);
    chk("t103_rst_laneDone", 32'(laneDone), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("t103_idle_busy", 32'(busy), 0);
    osMatch = '0;
    activeLanes = tbl[1].act;
    start_req(104, tbl[1].sub, tbl[1].f, tbl[1].e, tbl[1].lat);
    osMatch = tbl[1].act;
    @(posedge clk); #1;
    wait_done(104, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
